// File: rtl/cpu_uart_receiver.sv
// 8N1 UART receiver: 2-flop synchronizer, oversampling tick divider, frame FSM
// and a CPU-side status/acknowledge handshake with sticky error flags.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | line high, waiting for a falling start edge
// START     | qualifying the start bit at its centre
// DATA      | sampling 8 data bits at bit centres, LSB first
// STOP      | sampling the stop bit, publishing the byte or flagging FERR
// WAIT_HIGH | line must return high before another start is accepted
module cpu_uart_receiver #(
  parameter int CLKS_PER_TICK = 651,
  parameter int OVERSAMPLE    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       UART_RX,
  input  logic       RX_READ,
  output logic [7:0] RX_DATA,
  output logic       RX_STATUS,
  output logic       RX_FERR,
  output logic       RX_OVERRUN
);

  localparam int DW = (CLKS_PER_TICK > 2) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int TW = $clog2(OVERSAMPLE);

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLKS_PER_TICK - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

  logic          rx_meta;
  logic          rx_s;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [2:0]    state;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          frame_ok;
  logic          frame_bad;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_s    <= rx_meta;
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  // Restarting the divider on the start edge puts every sample point at a fixed
  // offset from that edge, independent of where the free-running phase was.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if ((state == ST_IDLE) && !rx_s) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  always_comb begin
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    if ((state == ST_STOP) && tick && (tick_cnt == TICK_LAST)) begin
      frame_ok  = rx_s;
      frame_bad = !rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tick_cnt <= '0;
          if (!rx_s) state <= ST_START;
        end
        ST_START: begin
          if (tick) begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_s ? ST_IDLE : ST_DATA;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (tick_cnt == TICK_LAST) begin
              shift_reg[bit_cnt] <= rx_s;
              tick_cnt           <= '0;
              bit_cnt            <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              state    <= ST_WAIT_HIGH;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        ST_WAIT_HIGH: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A completing byte takes priority over a coincident CPU acknowledge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      RX_DATA    <= 8'h00;
      RX_STATUS  <= 1'b0;
      RX_FERR    <= 1'b0;
      RX_OVERRUN <= 1'b0;
    end else begin
      if (frame_ok) begin
        RX_DATA   <= shift_reg;
        RX_STATUS <= 1'b1;
      end else if (RX_READ) begin
        RX_STATUS <= 1'b0;
      end

      if (frame_bad)    RX_FERR <= 1'b1;
      else if (RX_READ) RX_FERR <= 1'b0;

      if (frame_ok && RX_STATUS && !RX_READ) RX_OVERRUN <= 1'b1;
      else if (RX_READ)                      RX_OVERRUN <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_uart_receiver.sv
// Bench for cpu_uart_receiver: directed scenarios plus random frames, each
// checked against a frame-level model of the receiver's visible state.
module tb_cpu_uart_receiver;

  localparam int CPT   = 4;
  localparam int OS    = 16;
  localparam int BIT   = CPT * OS;
  localparam int FRAME = 10 * BIT;
  localparam int DONE  = (10 * OS - OS / 2) * CPT + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       UART_RX = 1'b1;
  logic       RX_READ = 1'b0;
  logic [7:0] RX_DATA;
  logic       RX_STATUS;
  logic       RX_FERR;
  logic       RX_OVERRUN;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_data;
  logic       m_status, m_ferr, m_ovr;
  int         lat;
  int         rises;
  logic       prev_status;

  cpu_uart_receiver #(.CLKS_PER_TICK(CPT), .OVERSAMPLE(OS)) dut (
    .clk        (clk),
    .reset      (reset),
    .UART_RX    (UART_RX),
    .RX_READ    (RX_READ),
    .RX_DATA    (RX_DATA),
    .RX_STATUS  (RX_STATUS),
    .RX_FERR    (RX_FERR),
    .RX_OVERRUN (RX_OVERRUN)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk_eq({tag, "_data"}, 32'(RX_DATA), 32'(m_data));
    chk_eq({tag, "_status"}, 32'(RX_STATUS), 32'(m_status));
    chk_eq({tag, "_ferr"}, 32'(RX_FERR), 32'(m_ferr));
    chk_eq({tag, "_ovr"}, 32'(RX_OVERRUN), 32'(m_ovr));
  endtask

  task automatic model_clear();
    m_status = 1'b0;
    m_ferr   = 1'b0;
    m_ovr    = 1'b0;
  endtask

  task automatic idle(input int n);
    UART_RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic read_pulse();
    @(negedge clk);
    RX_READ = 1'b1;
    @(negedge clk);
    RX_READ = 1'b0;
    model_clear();
  endtask

  // Drives one frame starting at the current negedge. rd_cyc / rst_cyc (0 = none)
  // place a read pulse or a 3-clk reset at that clock offset from the start edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input int rd_cyc, input int rst_cyc);
    logic [9:0] bits;
    logic       rd;
    bits = {stop_v, b, 1'b0};
    rd = (rd_cyc != 0);
    lat = 0;
    rises = 0;
    prev_status = RX_STATUS;
    UART_RX = 1'b0;
    for (int cyc = 1; cyc <= FRAME; cyc++) begin
      @(negedge clk);
      if (RX_STATUS && !prev_status) begin
        rises++;
        if (lat == 0) lat = cyc;
      end
      prev_status = RX_STATUS;
      RX_READ = (cyc == rd_cyc);
      if (rst_cyc != 0) reset = !(cyc >= rst_cyc && cyc < rst_cyc + 3);
      UART_RX = (cyc < FRAME) ? bits[cyc / BIT] : stop_v;
    end
    RX_READ = 1'b0;
    if (rst_cyc != 0) begin
      m_data = 8'h00;
      model_clear();
    end else begin
      // the read takes effect one clock after it is raised
      if (rd && (rd_cyc + 1 < DONE)) model_clear();
      if (stop_v) begin
        if (rd && (rd_cyc + 1 == DONE)) begin
          m_ferr = 1'b0;
          m_ovr  = 1'b0;
        end else if (m_status) begin
          m_ovr = 1'b1;
        end
        m_data   = b;
        m_status = 1'b1;
      end else begin
        if (rd && (rd_cyc + 1 == DONE)) begin
          m_status = 1'b0;
          m_ovr    = 1'b0;
        end
        m_ferr = 1'b1;
      end
      if (rd && (rd_cyc + 1 > DONE)) model_clear();
    end
  endtask

  initial begin
    int total_rises;
    logic [7:0] rb;
    logic       rs;
    int         rr;

    repeat (3) begin
      @(negedge clk);
      UART_RX = ~UART_RX;
    end
    m_data = 8'h00;
    model_clear();
    check_model("reset");
    reset = 1'b1;
    idle(10);

    send_frame(8'hA5, 1'b1, 0, 0);
    chk_eq("a5_latency", 32'(lat), 32'(DONE));
    check_model("a5");
    read_pulse();
    chk_eq("a5_read_status", 32'(RX_STATUS), 32'd0);
    idle(20);

    send_frame(8'h55, 1'b1, 0, 0);
    check_model("b2b_55");
    send_frame(8'hC3, 1'b1, 20, 0);
    chk_eq("c3_latency", 32'(lat), 32'(DONE));
    check_model("b2b_c3");
    send_frame(8'hF0, 1'b1, 30, 0);
    check_model("b2b_f0");
    send_frame(8'h0F, 1'b1, 0, 0);
    check_model("overrun_0f");
    read_pulse();
    check_model("overrun_read");
    idle(10);

    send_frame(8'h66, 1'b1, 0, 0);
    send_frame(8'h99, 1'b1, DONE - 1, 0);
    check_model("coincide_99");
    read_pulse();
    idle(10);

    UART_RX = 1'b0;
    repeat (20) @(negedge clk);
    idle(100);
    check_model("glitch");
    send_frame(8'h3C, 1'b1, 0, 0);
    chk_eq("3c_latency", 32'(lat), 32'(DONE));
    check_model("after_glitch_3c");
    read_pulse();
    idle(10);

    send_frame(8'h81, 1'b0, 0, 0);
    check_model("ferr_81");
    repeat (60) @(negedge clk);
    read_pulse();
    check_model("ferr_cleared");
    repeat (138) @(negedge clk);
    idle(700);
    check_model("ferr_no_restart");

    send_frame(8'hFF, 1'b1, 0, 5 * BIT + 10);
    total_rises = rises;
    check_model("rst_mid");
    idle(20);
    send_frame(8'h12, 1'b1, 0, 0);
    total_rises += rises;
    chk_eq("rst_12_latency", 32'(lat), 32'(DONE));
    chk_eq("rst_single_pulse", 32'(total_rises), 32'd1);
    check_model("rst_12");
    read_pulse();
    idle(10);

    for (int i = 0; i < 30; i++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 3))
        1:       rr = $urandom_range(1, FRAME - 2);
        2:       rr = DONE - 1;
        default: rr = 0;
      endcase
      send_frame(rb, rs, rr, 0);
      check_model($sformatf("rand%0d", i));
      if (!rs) begin
        repeat ($urandom_range(0, 80)) @(negedge clk);
        idle($urandom_range(4, 30));
      end else begin
        idle($urandom_range(0, 30));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
